// File: rtl/draw_background_anim.sv
// draw_background_anim
// Paints the VGA background behind the timing generator: coloured screen-edge
// border lines, a gray fill and one outlined box whose visibility can be
// steady, blinking, hidden, or blinking with a filled interior. The requested
// mode is latched only at the vsync rising edge, so a frame never shows a
// mix of two modes.
//
// Ports:
//   pclk, rst                 pixel clock, synchronous active-high reset
//   {v,h}count_in/sync/blnk   timing from the timing generator
//   state                     requested box mode (00 steady, 01 blink,
//                             10 hidden, 11 blink + interior fill)
//   {v,h}count_out/sync/blnk  timing delayed by 2 pclk
//   rgb_out                   pixel colour aligned with the delayed timing
module draw_background_anim #(
   parameter int          H_ACTIVE     = 1024,
   parameter int          V_ACTIVE     = 768,
   parameter int          BOX_X0       = 249,
   parameter int          BOX_Y0       = 149,
   parameter int          BOX_W        = 301,
   parameter int          BOX_H        = 101,
   parameter int          BOX_THICK    = 2,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [11:0] BOX_RGB      = 12'hc61,
   parameter logic [11:0] FILL_RGB     = 12'h36c,
   parameter logic [11:0] BG_RGB       = 12'h888
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [10:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [1:0]  state,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out
);

   localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

   localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
   localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

   // Outer rectangle and the rectangle strictly inside the outline.
   localparam logic [10:0] BX0 = 11'(BOX_X0);
   localparam logic [10:0] BX1 = 11'(BOX_X0 + BOX_W - 1);
   localparam logic [10:0] BY0 = 11'(BOX_Y0);
   localparam logic [10:0] BY1 = 11'(BOX_Y0 + BOX_H - 1);
   localparam logic [10:0] IX0 = 11'(BOX_X0 + BOX_THICK);
   localparam logic [10:0] IX1 = 11'(BOX_X0 + BOX_W - 1 - BOX_THICK);
   localparam logic [10:0] IY0 = 11'(BOX_Y0 + BOX_THICK);
   localparam logic [10:0] IY1 = 11'(BOX_Y0 + BOX_H - 1 - BOX_THICK);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Stage 1 registers
   logic [10:0] vcount_s1_reg, hcount_s1_reg;
   logic        vsync_s1_reg, vblnk_s1_reg, hsync_s1_reg, hblnk_s1_reg;
   logic        blank_s1_reg, top_s1_reg, bottom_s1_reg, left_s1_reg, right_s1_reg;
   logic        outline_s1_reg, interior_s1_reg;

   // Frame-level animation state
   logic             vsync_d_reg;
   logic [1:0]       mode_reg;
   logic [CNT_W-1:0] frame_cnt_reg;
   logic             blink_vis_reg;

   logic        in_box, in_inner, fb, box_vis;
   logic [11:0] rgb_next;

   assign in_box   = (hcount_in >= BX0) && (hcount_in <= BX1) &&
                     (vcount_in >= BY0) && (vcount_in <= BY1);
   assign in_inner = (hcount_in >= IX0) && (hcount_in <= IX1) &&
                     (vcount_in >= IY0) && (vcount_in <= IY1);

   assign fb = vsync_in && !vsync_d_reg;

   // Stage 1: register timing and decoded position flags.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vcount_s1_reg   <= '0;
         hcount_s1_reg   <= '0;
         vsync_s1_reg    <= 1'b0;
         vblnk_s1_reg    <= 1'b0;
         hsync_s1_reg    <= 1'b0;
         hblnk_s1_reg    <= 1'b0;
         blank_s1_reg    <= 1'b0;
         top_s1_reg      <= 1'b0;
         bottom_s1_reg   <= 1'b0;
         left_s1_reg     <= 1'b0;
         right_s1_reg    <= 1'b0;
         outline_s1_reg  <= 1'b0;
         interior_s1_reg <= 1'b0;
      end else begin
         vcount_s1_reg   <= vcount_in;
         hcount_s1_reg   <= hcount_in;
         vsync_s1_reg    <= vsync_in;
         vblnk_s1_reg    <= vblnk_in;
         hsync_s1_reg    <= hsync_in;
         hblnk_s1_reg    <= hblnk_in;
         blank_s1_reg    <= vblnk_in || hblnk_in;
         top_s1_reg      <= (vcount_in == 11'd0);
         bottom_s1_reg   <= (vcount_in == V_LAST);
         left_s1_reg     <= (hcount_in == 11'd0);
         right_s1_reg    <= (hcount_in == H_LAST);
         outline_s1_reg  <= in_box && !in_inner;
         interior_s1_reg <= in_inner;
      end
   end

   // Mode and blink state change only on the vsync rising edge.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vsync_d_reg   <= 1'b0;
         mode_reg      <= 2'b00;
         frame_cnt_reg <= '0;
         blink_vis_reg <= 1'b1;
      end else begin
         vsync_d_reg <= vsync_in;
         if (fb) begin
            if (state != mode_reg) begin
               mode_reg      <= state;
               frame_cnt_reg <= '0;
               blink_vis_reg <= 1'b1;
            end else if (mode_reg[0]) begin
               if (frame_cnt_reg == CNT_LAST) begin
                  frame_cnt_reg <= '0;
                  blink_vis_reg <= !blink_vis_reg;
               end else begin
                  frame_cnt_reg <= frame_cnt_reg + CNT_ONE;
               end
            end else begin
               frame_cnt_reg <= '0;
               blink_vis_reg <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      case (mode_reg)
         2'b00:   box_vis = 1'b1;
         2'b10:   box_vis = 1'b0;
         default: box_vis = blink_vis_reg;
      endcase
   end

   // Colour priority: blanking, then borders, then box, then background.
   always_comb begin
      rgb_next = BG_RGB;
      if (blank_s1_reg)                                 rgb_next = 12'h000;
      else if (top_s1_reg)                              rgb_next = 12'hff0;
      else if (bottom_s1_reg)                           rgb_next = 12'hf00;
      else if (left_s1_reg)                             rgb_next = 12'h0f0;
      else if (right_s1_reg)                            rgb_next = 12'h00f;
      else if (outline_s1_reg && box_vis)               rgb_next = BOX_RGB;
      else if (interior_s1_reg && box_vis && mode_reg == 2'b11)
                                                        rgb_next = FILL_RGB;
   end

   // Stage 2: registered outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vcount_out <= '0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         hcount_out <= '0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         vcount_out <= vcount_s1_reg;
         vsync_out  <= vsync_s1_reg;
         vblnk_out  <= vblnk_s1_reg;
         hcount_out <= hcount_s1_reg;
         hsync_out  <= hsync_s1_reg;
         hblnk_out  <= hblnk_s1_reg;
         rgb_out    <= rgb_next;
      end
   end

endmodule

// File: tb/tb_draw_background_anim.sv
// Directed bench for draw_background_anim (BLINK_FRAMES overridden to 2).
module tb_draw_background_anim;

   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
   logic [1:0]  state;
   logic [10:0] vcount_out, hcount_out;
   logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
   logic [11:0] rgb_out;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   draw_background_anim #(.BLINK_FRAMES(2)) dut (
      .pclk(pclk), .rst(rst),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .state(state),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .rgb_out(rgb_out)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int h, input int v, input logic hb);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = hb;
      vblnk_in  = 1'b0;
      hsync_in  = 1'b0;
      vsync_in  = 1'b0;
   endtask

   // Present one pixel, wait the 2-cycle latency, check colour and alignment.
   task automatic px(input string tag, input int h, input int v, input logic hb,
                     input logic [11:0] exp);
      drive(h, v, hb);
      tick();
      tick();
      $display("[TB] %s h=%0d v=%0d rgb=%h", tag, h, v, rgb_out);
      check(tag, rgb_out, exp);
      check({tag, "_h"}, {1'b0, hcount_out}, 12'(h));
   endtask

   // One blanked vsync pulse: a single frame-boundary event.
   task automatic frame();
      vblnk_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b0;
      tick(); tick();
      vsync_in = 1'b1;
      tick(); tick(); tick();
      vsync_in = 1'b0;
      tick();
      vblnk_in = 1'b0; hblnk_in = 1'b0;
      $display("[TB] frame boundary, state=%b", state);
   endtask

   initial begin
      rst = 1'b1; state = 2'b00;
      drive(0, 0, 1'b0);
      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         hcount_in = 11'($urandom);
         vcount_in = 11'($urandom);
         {vsync_in, vblnk_in, hsync_in, hblnk_in} = 4'($urandom);
         tick();
         check("rst_rgb", rgb_out, 12'h000);
         check("rst_sync", {8'h00, vsync_out, vblnk_out, hsync_out, hblnk_out}, 12'h000);
         check("rst_cnt", {1'b0, hcount_out | vcount_out}, 12'h000);
      end
      rst = 1'b0;
      px("post_rst", 5, 5, 1'b0, 12'h888);

      // Edge sweep, steady mode
      px("left",   0,    10,  1'b0, 12'h0f0);
      px("right",  1023, 10,  1'b0, 12'h00f);
      px("top",    10,   0,   1'b0, 12'hff0);
      px("bottom", 10,   767, 1'b0, 12'hf00);
      px("box_tl", 249,  149, 1'b0, 12'hc61);
      px("box_l2", 250,  200, 1'b0, 12'hc61);
      px("inner",  251,  151, 1'b0, 12'h888);
      px("box_br", 549,  249, 1'b0, 12'hc61);
      px("outside",550,  249, 1'b0, 12'h888);
      px("hblank", 249,  149, 1'b1, 12'h000);

      // Timing passthrough
      drive(300, 400, 1'b1);
      hsync_in = 1'b1;
      tick(); tick();
      check("hsync_pass", {10'd0, hsync_out, hblnk_out}, 12'h003);
      check("vcount_pass", {1'b0, vcount_out}, 12'd400);

      // Deferred mode change 00 -> 10 -> 00
      state = 2'b10;
      px("defer_hide", 249, 149, 1'b0, 12'hc61);
      frame();
      px("hidden", 249, 149, 1'b0, 12'h888);
      state = 2'b00;
      px("defer_show", 249, 149, 1'b0, 12'h888);
      frame();
      px("shown", 249, 149, 1'b0, 12'hc61);

      // Blink, two frames per half-period
      state = 2'b01;
      frame();
      px("blink_f1", 249, 149, 1'b0, 12'hc61);
      frame();
      px("blink_f2", 249, 149, 1'b0, 12'hc61);
      frame();
      px("blink_f3", 249, 149, 1'b0, 12'h888);
      frame();
      px("blink_f4", 249, 149, 1'b0, 12'h888);
      frame();
      px("blink_f5", 249, 149, 1'b0, 12'hc61);

      // Blink with interior fill
      state = 2'b11;
      frame();
      px("fill_in1",  400, 200, 1'b0, 12'h36c);
      px("fill_out1", 249, 149, 1'b0, 12'hc61);
      px("fill_brd1", 0,   200, 1'b0, 12'h0f0);
      frame();
      px("fill_in2",  400, 200, 1'b0, 12'h36c);
      frame();
      px("fill_in3",  400, 200, 1'b0, 12'h888);
      px("fill_out3", 249, 149, 1'b0, 12'h888);
      px("fill_brd3", 0,   200, 1'b0, 12'h0f0);

      // Mid-frame reset while blinking and hidden
      state = 2'b01;
      frame();
      frame();
      frame();
      px("pre_rst_hidden", 249, 149, 1'b0, 12'h888);
      drive(400, 5, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check("midrst_rgb", rgb_out, 12'h000);
      check("midrst_h", {1'b0, hcount_out}, 12'h000);
      rst = 1'b0;
      px("after_rst", 249, 149, 1'b0, 12'hc61);
      frame();
      px("after_rst_fb", 249, 149, 1'b0, 12'hc61);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
